// File: rtl/agc_ctrl_seq.sv
// rtl/agc_ctrl_seq.sv - AGC multi-cycle control sequencer; DV extracode enabled by AGC_CTRL_DV_EN
module agc_ctrl_seq #(
   parameter int                ADDR_W      = 12,
   parameter int                TP_PER_MCT  = 12,
   parameter int                MP_MCT      = 3,
   parameter int                DV_MCT      = 6,
   parameter logic [ADDR_W-1:0] EXTEND_ADDR = 12'd6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        op,
   input  logic [1:0]        qc,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        operand_class,
   input  logic              acc_ovf,
   output logic [3:0]        seq_code,
   output logic [2:0]        mct,
   output logic [3:0]        tp,
   output logic              oper_rd,
   output logic              oper_wr,
   output logic              alu_go,
   output logic              z_load,
   output logic [1:0]        z_step,
   output logic              done,
   output logic              ext_active,
   output logic              index_pending,
   output logic              illegal,
   output logic [1:0]        cur_qc,
   output logic [ADDR_W-1:0] cur_addr
);

   // Instruction codes as presented on seq_code
   localparam logic [3:0] C_TC     = 4'd0;
   localparam logic [3:0] C_CCS    = 4'd1;
   localparam logic [3:0] C_DV     = 4'd2;
   localparam logic [3:0] C_INDEX  = 4'd3;
   localparam logic [3:0] C_XCH    = 4'd4;
   localparam logic [3:0] C_CS     = 4'd5;
   localparam logic [3:0] C_TS     = 4'd6;
   localparam logic [3:0] C_AD     = 4'd7;
   localparam logic [3:0] C_SU     = 4'd8;
   localparam logic [3:0] C_MASK   = 4'd9;
   localparam logic [3:0] C_MP     = 4'd10;
   localparam logic [3:0] C_EXTEND = 4'd11;
   localparam logic [3:0] C_NONE   = 4'd15;

   // Timepulse landmarks within an MCT
   localparam logic [3:0] TP_END = 4'(TP_PER_MCT);
   localparam logic [3:0] TP_MID = 4'(TP_PER_MCT / 2);
   localparam logic [3:0] TP_WR  = 4'(TP_PER_MCT - 1);
   localparam logic [2:0] MP_N   = 3'(MP_MCT);
   localparam logic [2:0] DV_N   = 3'(DV_MCT);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t     state;
   logic [2:0] n_mct;
   logic [1:0] cls_q;
   logic       ovf_q;

   logic [3:0] dec_code;
   logic       dec_bad;
   logic [2:0] dec_mct;
   logic       running;
   logic       in_mct1;

   // Decode the presented opcode against the current EXTEND state
   always_comb begin
      dec_code = C_NONE;
      dec_bad  = 1'b0;
      case (op)
         3'b000: dec_code = (addr == EXTEND_ADDR) ? C_EXTEND : C_TC;
         3'b001: begin
            if (ext_active) begin
`ifdef AGC_CTRL_DV_EN
               dec_code = C_DV;
`else
               dec_code = C_NONE;
               dec_bad  = 1'b1;
`endif
            end else begin
               dec_code = C_CCS;
            end
         end
         3'b010: dec_code = C_INDEX;
         3'b011: dec_code = C_XCH;
         3'b100: dec_code = C_CS;
         3'b101: dec_code = C_TS;
         3'b110: dec_code = ext_active ? C_SU : C_AD;
         3'b111: dec_code = ext_active ? C_MP : C_MASK;
         default: begin
            dec_code = C_NONE;
            dec_bad  = 1'b1;
         end
      endcase
   end

   // Number of MCTs the decoded instruction occupies
   always_comb begin
      dec_mct = 3'd2;
      case (dec_code)
         C_TC, C_EXTEND, C_NONE: dec_mct = 3'd1;
         C_MP:                   dec_mct = MP_N;
         C_DV:                   dec_mct = DV_N;
         default:                dec_mct = 3'd2;
      endcase
   end

   // Sequencer FSM: accept, step timepulses/MCTs, update latches at completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         instr_ready   <= 1'b0;
         seq_code      <= C_NONE;
         mct           <= 3'd0;
         tp            <= 4'd0;
         n_mct         <= 3'd0;
         cls_q         <= 2'd0;
         ovf_q         <= 1'b0;
         illegal       <= 1'b0;
         ext_active    <= 1'b0;
         index_pending <= 1'b0;
         cur_qc        <= 2'd0;
         cur_addr      <= '0;
      end else begin
         illegal <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid && instr_ready) begin
                  state       <= RUN;
                  instr_ready <= 1'b0;
                  seq_code    <= dec_code;
                  n_mct       <= dec_mct;
                  mct         <= 3'd1;
                  tp          <= 4'd1;
                  cls_q       <= 2'd0;
                  ovf_q       <= 1'b0;
                  illegal     <= dec_bad;
                  cur_qc      <= qc;
                  cur_addr    <= addr;
               end else begin
                  instr_ready <= 1'b1;
               end
            end
            RUN: begin
               if (in_mct1 && tp == TP_MID) begin
                  cls_q <= operand_class;
               end
               if (in_mct1 && tp == TP_WR) begin
                  ovf_q <= acc_ovf;
               end
               if (done) begin
                  state       <= IDLE;
                  instr_ready <= 1'b1;
                  seq_code    <= C_NONE;
                  mct         <= 3'd0;
                  tp          <= 4'd0;
                  // INDEX leaves the EXTEND latch alone so INDEX can sit between EXTEND and its extracode
                  if (seq_code == C_EXTEND) begin
                     ext_active <= 1'b1;
                  end else if (seq_code != C_INDEX) begin
                     ext_active <= 1'b0;
                  end
                  index_pending <= (seq_code == C_INDEX);
               end else if (tp == TP_END) begin
                  tp  <= 4'd1;
                  mct <= mct + 3'd1;
               end else begin
                  tp <= tp + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Datapath strobes decoded from the registered sequencer position
   always_comb begin
      running = (state == RUN);
      in_mct1 = (mct == 3'd1);
      done    = running && (tp == TP_END) && (mct == n_mct);

      oper_rd = running && in_mct1 && (tp == 4'd2) &&
                (seq_code != C_TC) && (seq_code != C_EXTEND) &&
                (seq_code != C_TS) && (seq_code != C_NONE);

      oper_wr = running && in_mct1 && (tp == TP_WR) &&
                ((seq_code == C_XCH) || (seq_code == C_TS));

      alu_go  = running && (tp == TP_MID) &&
                ((seq_code == C_CCS) || (seq_code == C_DV) || (seq_code == C_AD) ||
                 (seq_code == C_SU) || (seq_code == C_MASK) || (seq_code == C_MP));

      z_load  = done && (seq_code == C_TC);
   end

   // Z increment reported alongside done
   always_comb begin
      z_step = 2'd0;
      if (done) begin
         case (seq_code)
            C_TC:    z_step = 2'd0;
            C_CCS:   z_step = cls_q;
            C_TS:    z_step = ovf_q ? 2'd2 : 2'd1;
            default: z_step = 2'd1;
         endcase
      end
   end

endmodule

// File: tb/tb_agc_ctrl_seq.sv
// tb/tb_agc_ctrl_seq.sv - randomized and directed bench for agc_ctrl_seq against a cycle-index model
module tb_agc_ctrl_seq;

   localparam int TP  = 12;
   localparam int MPN = 3;
   localparam int DVN = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  op;
   logic [1:0]  qc;
   logic [11:0] addr;
   logic [1:0]  operand_class;
   logic        acc_ovf;
   logic [3:0]  seq_code;
   logic [2:0]  mct;
   logic [3:0]  tp;
   logic        oper_rd, oper_wr, alu_go, z_load, done;
   logic [1:0]  z_step;
   logic        ext_active, index_pending, illegal;
   logic [1:0]  cur_qc;
   logic [11:0] cur_addr;

   agc_ctrl_seq #(
      .ADDR_W(12), .TP_PER_MCT(TP), .MP_MCT(MPN), .DV_MCT(DVN), .EXTEND_ADDR(12'd6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .op(op), .qc(qc), .addr(addr), .operand_class(operand_class), .acc_ovf(acc_ovf),
      .seq_code(seq_code), .mct(mct), .tp(tp), .oper_rd(oper_rd), .oper_wr(oper_wr),
      .alu_go(alu_go), .z_load(z_load), .z_step(z_step), .done(done),
      .ext_active(ext_active), .index_pending(index_pending), .illegal(illegal),
      .cur_qc(cur_qc), .cur_addr(cur_addr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state
   int  m_ext, m_idx, m_qc, m_addr, m_first;
   int  run_k;
   bit  chk_en = 1'b0;

   // expected outputs for the current cycle
   int exp_ready, exp_seq, exp_mct, exp_tp, exp_rd, exp_wr, exp_alu;
   int exp_zl, exp_zs, exp_done, exp_ext, exp_idx, exp_ill, exp_qc, exp_addr;

   // observations of the DUT for literal checks
   int obs_done_k, obs_z, obs_alu_first, obs_alu_cnt, obs_wr_k, obs_rd_k, obs_ill_k;

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, expv, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_exp();
      exp_ready = m_first ? 0 : 1;
      exp_seq = 15; exp_mct = 0; exp_tp = 0;
      exp_rd = 0; exp_wr = 0; exp_alu = 0; exp_zl = 0; exp_zs = 0; exp_done = 0; exp_ill = 0;
      exp_ext = m_ext; exp_idx = m_idx; exp_qc = m_qc; exp_addr = m_addr;
   endtask

   task automatic set_reset_exp();
      exp_ready = 0; exp_seq = 15; exp_mct = 0; exp_tp = 0;
      exp_rd = 0; exp_wr = 0; exp_alu = 0; exp_zl = 0; exp_zs = 0; exp_done = 0; exp_ill = 0;
      exp_ext = 0; exp_idx = 0; exp_qc = 0; exp_addr = 0;
   endtask

   task automatic clear_obs();
      obs_done_k = 0; obs_z = -1; obs_alu_first = 0; obs_alu_cnt = 0;
      obs_wr_k = 0; obs_rd_k = 0; obs_ill_k = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         instr_valid = 1'b0;
         op = 3'($urandom); addr = 12'($urandom); qc = 2'($urandom);
         run_k = 0;
         set_idle_exp();
         cyc();
         m_first = 0;
      end
   endtask

   // Issue one instruction and walk it to completion (or abort with reset at run cycle abort_k)
   task automatic issue(input logic [2:0] o, input logic [11:0] a, input logic [1:0] q,
                        input int fcls, input int fovf, input int abort_k);
      int c, n, ill, zs, s_cls, s_ovf, m, t, last;
      ill = 0;
      case (o)
         3'd0: c = (a == 12'd6) ? 11 : 0;
         3'd1: begin
            if (m_ext != 0) begin
`ifdef AGC_CTRL_DV_EN
               c = 2;
`else
               c = 15; ill = 1;
`endif
            end else begin
               c = 1;
            end
         end
         3'd2: c = 3;
         3'd3: c = 4;
         3'd4: c = 5;
         3'd5: c = 6;
         3'd6: c = (m_ext != 0) ? 8 : 7;
         default: c = (m_ext != 0) ? 10 : 9;
      endcase
      if (c == 0 || c == 11 || c == 15) n = 1;
      else if (c == 10) n = MPN;
      else if (c == 2) n = DVN;
      else n = 2;
      s_cls = 0; s_ovf = 0;

      instr_valid = 1'b1; op = o; addr = a; qc = q;
      run_k = 0;
      set_idle_exp();
      clear_obs();
      cyc();
      m_qc = q; m_addr = a;

      for (int k = 1; k <= n * TP; k++) begin
         run_k = k;
         operand_class = (fcls >= 0) ? 2'(fcls) : 2'($urandom);
         acc_ovf       = (fovf >= 0) ? 1'(fovf) : 1'($urandom);
         instr_valid   = 1'($urandom);
         op = 3'($urandom); addr = 12'($urandom); qc = 2'($urandom);
         if (k == TP / 2) s_cls = operand_class;
         if (k == TP - 1) s_ovf = acc_ovf;
         m    = (k - 1) / TP + 1;
         t    = (k - 1) % TP + 1;
         last = (k == n * TP) ? 1 : 0;
         if (c == 0) zs = 0;
         else if (c == 1) zs = s_cls;
         else if (c == 6) zs = s_ovf ? 2 : 1;
         else zs = 1;
         exp_ready = 0; exp_seq = c; exp_mct = m; exp_tp = t;
         exp_rd   = (k == 2 && c != 0 && c != 11 && c != 6 && c != 15) ? 1 : 0;
         exp_wr   = (k == TP - 1 && (c == 4 || c == 6)) ? 1 : 0;
         exp_alu  = (t == TP / 2 && (c == 1 || c == 2 || (c >= 7 && c <= 10))) ? 1 : 0;
         exp_done = last;
         exp_zl   = (last != 0 && c == 0) ? 1 : 0;
         exp_zs   = last ? zs : 0;
         exp_ill  = (k == 1) ? ill : 0;
         exp_ext = m_ext; exp_idx = m_idx; exp_qc = m_qc; exp_addr = m_addr;
         if (k == abort_k) begin
            rst_n = 1'b0;
            set_reset_exp();
            cyc();
            rst_n = 1'b1;
            m_ext = 0; m_idx = 0; m_qc = 0; m_addr = 0; m_first = 1;
            idle(1);
            return;
         end
         cyc();
      end
      if (c == 11) m_ext = 1;
      else if (c != 3) m_ext = 0;
      m_idx = (c == 3) ? 1 : 0;
      run_k = 0;
      instr_valid = 1'b0;
      set_idle_exp();
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("instr_ready", instr_ready, exp_ready);
         chk("seq_code", seq_code, exp_seq);
         chk("mct", mct, exp_mct);
         chk("tp", tp, exp_tp);
         chk("oper_rd", oper_rd, exp_rd);
         chk("oper_wr", oper_wr, exp_wr);
         chk("alu_go", alu_go, exp_alu);
         chk("z_load", z_load, exp_zl);
         chk("z_step", z_step, exp_zs);
         chk("done", done, exp_done);
         chk("ext_active", ext_active, exp_ext);
         chk("index_pending", index_pending, exp_idx);
         chk("illegal", illegal, exp_ill);
         chk("cur_qc", cur_qc, exp_qc);
         chk("cur_addr", cur_addr, exp_addr);
         if (done) begin obs_done_k = run_k; obs_z = z_step; end
         if (alu_go) begin
            if (obs_alu_first == 0) obs_alu_first = run_k;
            obs_alu_cnt++;
         end
         if (oper_wr) obs_wr_k = run_k;
         if (oper_rd) obs_rd_k = run_k;
         if (illegal) obs_ill_k = run_k;
      end
   end

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; op = 3'd0; addr = 12'd0; qc = 2'd0;
      operand_class = 2'd0; acc_ovf = 1'b0;
      m_ext = 0; m_idx = 0; m_qc = 0; m_addr = 0; m_first = 1; run_k = 0;
      clear_obs();
      set_reset_exp();
      chk_en = 1'b1;
      cyc();
      chk("rst_seq_code", seq_code, 15);
      chk("rst_ready", instr_ready, 0);
      cyc();
      rst_n = 1'b1;
      idle(1);
      chk("ready_after_first_edge", instr_ready, 1);
      idle(1);

      // AD: rd at 2, alu at 6/18, done at 24
      issue(3'd6, 12'd100, 2'd1, -1, -1, 0);
      chk("ad_rd_k", obs_rd_k, 2);
      chk("ad_alu_first", obs_alu_first, 6);
      chk("ad_alu_cnt", obs_alu_cnt, 2);
      chk("ad_done_k", obs_done_k, 24);
      chk("ad_zstep", obs_z, 1);
      chk("ad_ready_after", instr_ready, 1);

      // EXTEND then MP
      issue(3'd0, 12'd6, 2'd0, -1, -1, 0);
      chk("ext_done_k", obs_done_k, 12);
      chk("ext_set", ext_active, 1);
      issue(3'd7, 12'd55, 2'd2, -1, -1, 0);
      chk("mp_done_k", obs_done_k, 36);
      chk("mp_alu_cnt", obs_alu_cnt, 3);
      chk("mp_ext_clr", ext_active, 0);

      // TC z_load / z_step 0
      issue(3'd0, 12'd7, 2'd3, -1, -1, 0);
      chk("tc_done_k", obs_done_k, 12);
      chk("tc_zstep", obs_z, 0);

      // CCS operand classes
      issue(3'd1, 12'd20, 2'd0, 3, -1, 0);
      chk("ccs_m0_zstep", obs_z, 3);
      issue(3'd1, 12'd21, 2'd0, 0, -1, 0);
      chk("ccs_pos_zstep", obs_z, 0);

      // TS overflow
      issue(3'd5, 12'd30, 2'd1, -1, 1, 0);
      chk("ts_wr_k", obs_wr_k, 11);
      chk("ts_ovf_zstep", obs_z, 2);
      chk("ts_no_rd", obs_rd_k, 0);
      issue(3'd5, 12'd31, 2'd1, -1, 0, 0);
      chk("ts_zstep", obs_z, 1);

      // INDEX then XCH
      issue(3'd2, 12'd40, 2'd0, -1, -1, 0);
      chk("index_set", index_pending, 1);
      issue(3'd3, 12'd41, 2'd0, -1, -1, 0);
      chk("xch_rd_k", obs_rd_k, 2);
      chk("xch_wr_k", obs_wr_k, 11);
      chk("index_clr", index_pending, 0);

      // EXTEND + INDEX keeps ext_active
      issue(3'd0, 12'd6, 2'd0, -1, -1, 0);
      issue(3'd2, 12'd9, 2'd0, -1, -1, 0);
      chk("index_keeps_ext", ext_active, 1);
      issue(3'd6, 12'd9, 2'd0, -1, -1, 0);
      chk("su_ext_clr", ext_active, 0);

`ifdef AGC_CTRL_DV_EN
      issue(3'd0, 12'd6, 2'd0, -1, -1, 0);
      issue(3'd1, 12'd77, 2'd2, -1, -1, 3 * TP + 5);
      chk("dv_abort_no_done", obs_done_k, 0);
      chk("dv_abort_ext", ext_active, 0);
      issue(3'd0, 12'd6, 2'd0, -1, -1, 0);
      issue(3'd1, 12'd78, 2'd2, -1, -1, 0);
      chk("dv_done_k", obs_done_k, 72);
`else
      issue(3'd0, 12'd6, 2'd0, -1, -1, 0);
      issue(3'd1, 12'd77, 2'd2, -1, -1, 0);
      chk("dv_off_illegal_k", obs_ill_k, 1);
      chk("dv_off_done_k", obs_done_k, 12);
      chk("dv_off_zstep", obs_z, 1);
      issue(3'd0, 12'd6, 2'd0, -1, -1, 0);
      issue(3'd7, 12'd78, 2'd2, -1, -1, TP + 5);
      chk("mp_abort_no_done", obs_done_k, 0);
      chk("mp_abort_ext", ext_active, 0);
`endif

      // Randomized instruction stream
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  ro;
         logic [11:0] ra;
         int          ab;
         ro = 3'($urandom_range(0, 7));
         ra = ($urandom_range(0, 2) == 0) ? 12'd6 : 12'($urandom);
         ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, TP)) : 0;
         issue(ro, ra, 2'($urandom), -1, -1, ab);
         idle($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
